// File: rtl/fetch_buffer_if.sv
// Handshake bundle between the fetch buffer, instruction memory and decode.
// The master modport is the fetch buffer's view; slave is the surrounding system.
interface fetch_buffer_if;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_req_ready;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;

  modport master (
    input  i_redirect, i_redirect_pc, i_mem_req_ready, i_mem_rsp_valid,
           i_mem_rsp_data, i_inst_ready,
    output o_mem_req_valid, o_mem_req_addr, o_inst_valid, o_inst, o_inst_pc
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_mem_req_ready, i_mem_rsp_valid,
           i_mem_rsp_data, i_inst_ready,
    input  o_mem_req_valid, o_mem_req_addr, o_inst_valid, o_inst, o_inst_pc
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues sequential word fetches, holds in-order responses in a
// DEPTH-slot FIFO for decode, and discards responses from streams abandoned by a redirect.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic            i_clk,
  input logic            i_rst,
  fetch_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [DEPTH-1:0] slot_alloc;
  logic [DEPTH-1:0] slot_filled;
  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW-1:0]    pend;
  logic [CW-1:0]    count;
  logic [CW-1:0]    live;
  logic [CW-1:0]    drop;
  logic [CW:0]      inflight;
  logic [CW:0]      inflight_after_rsp;
  logic             issue;
  logic             fill;
  logic             pop;
  logic             drop_rsp;

  // Stale responses (drop) still occupy memory's pipeline, so they count against issue credit.
  assign inflight = {1'b0, live} + {1'b0, drop};
  assign inflight_after_rsp = (bus.i_mem_rsp_valid && (inflight != '0)) ?
                              inflight - (CW+1)'(1) : inflight;

  assign bus.o_mem_req_valid = !i_rst && !bus.i_redirect && (count < DEPTH_C) &&
                               (inflight < DEPTH_W);
  assign bus.o_mem_req_addr  = fetch_pc;
  assign bus.o_inst_valid    = slot_alloc[head] && slot_filled[head];
  assign bus.o_inst          = slot_data[head];
  assign bus.o_inst_pc       = slot_pc[head];

  assign issue    = bus.o_mem_req_valid && bus.i_mem_req_ready;
  assign drop_rsp = bus.i_mem_rsp_valid && (drop != '0);
  assign fill     = bus.i_mem_rsp_valid && (drop == '0) && (live != '0);
  assign pop      = bus.o_inst_valid && bus.i_inst_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      slot_alloc  <= '0;
      slot_filled <= '0;
      head        <= '0;
      tail        <= '0;
      pend        <= '0;
      count       <= '0;
      live        <= '0;
      drop        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else if (bus.i_redirect) begin
      // Everything in flight for the old stream becomes stale; a same-cycle response retires one.
      fetch_pc    <= bus.i_redirect_pc & ~32'h3;
      slot_alloc  <= '0;
      slot_filled <= '0;
      head        <= '0;
      tail        <= '0;
      pend        <= '0;
      count       <= '0;
      live        <= '0;
      drop        <= CW'(inflight_after_rsp);
    end else begin
      if (issue) begin
        fetch_pc          <= fetch_pc + 32'd4;
        slot_alloc[tail]  <= 1'b1;
        slot_filled[tail] <= 1'b0;
        slot_pc[tail]     <= fetch_pc;
        tail              <= tail + AW'(1);
      end
      // Responses are in order, so the oldest pending slot is always the one being answered.
      if (fill) begin
        slot_filled[pend] <= 1'b1;
        slot_data[pend]   <= bus.i_mem_rsp_data;
        pend              <= pend + AW'(1);
      end
      if (pop) begin
        slot_alloc[head] <= 1'b0;
        head             <= head + AW'(1);
      end
      if (drop_rsp) begin
        drop <= drop - CW'(1);
      end
      count <= count + CW'(issue) - CW'(pop);
      live  <= live + CW'(issue) - CW'(fill);
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a queue-based memory model answers requests one cycle later
// (or later when held), and each scenario task checks hand-computed outputs at the falling edge.
module tb_fetch_buffer;
  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic mem_hold = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] req_q[$];
  logic [31:0] issue_log[$];

  fetch_buffer_if bus();

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: a request seen valid&&ready at a falling edge handshakes at the next rising
  // edge and is answered from the falling edge after that; reset drains everything.
  always @(negedge clk) begin
    if (rst) begin
      req_q.delete();
      issue_log.delete();
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rsp_data  = '0;
    end else begin
      bus.i_mem_rsp_valid = 1'b0;
      if (!mem_hold && req_q.size() > 0) begin
        bus.i_mem_rsp_data  = req_q.pop_front();
        bus.i_mem_rsp_valid = 1'b1;
      end
      if (bus.o_mem_req_valid && bus.i_mem_req_ready) begin
        req_q.push_back(bus.o_mem_req_addr);
        issue_log.push_back(bus.o_mem_req_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset(input logic inst_ready, input logic req_ready);
    @(posedge clk);
    #1;
    rst                 = 1'b1;
    bus.i_redirect      = 1'b0;
    bus.i_redirect_pc   = '0;
    bus.i_mem_req_ready = req_ready;
    bus.i_inst_ready    = inst_ready;
    mem_hold            = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    bus.i_redirect      = 1'b0;
    bus.i_redirect_pc   = '0;
    bus.i_mem_req_ready = 1'b1;
    bus.i_inst_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.o_mem_req_valid, bus.o_inst_valid} !== 2'b00)
      $display("[TB] FAIL reset_valids: got %b expected 00", {bus.o_mem_req_valid, bus.o_inst_valid});
    else n_pass++;
    n_checks++;
    if (bus.o_mem_req_addr !== 32'h0)
      $display("[TB] FAIL reset_addr: got %h expected 00000000", bus.o_mem_req_addr);
    else n_pass++;
    n_checks++;
    if (bus.o_inst !== 32'h0)
      $display("[TB] FAIL reset_inst: got %h expected 00000000", bus.o_inst);
    else n_pass++;
    n_checks++;
    if (bus.o_inst_pc !== 32'h0)
      $display("[TB] FAIL reset_inst_pc: got %h expected 00000000", bus.o_inst_pc);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_mem_req_valid, bus.o_mem_req_addr} !== {1'b1, 32'h0})
      $display("[TB] FAIL reset_release_req: got %b/%h expected 1/00000000",
               bus.o_mem_req_valid, bus.o_mem_req_addr);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp = 32'(4 * k);
      n_checks++;
      if ({bus.o_inst_valid, bus.o_inst_pc, bus.o_inst} !== {1'b1, exp, exp})
        $display("[TB] FAIL stream_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, exp, exp);
      else n_pass++;
      @(posedge clk);
    end
  endtask

  task automatic test_decode_stall();
    logic [31:0] exp;
    do_reset(1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (issue_log.size() != 4 ||
        {issue_log[0], issue_log[1], issue_log[2], issue_log[3]} !==
        {32'h0, 32'h4, 32'h8, 32'hC})
      $display("[TB] FAIL stall_issues: got %0d requests expected 4 (0,4,8,c)", issue_log.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.o_mem_req_valid !== 1'b0)
      $display("[TB] FAIL stall_req_valid: got %b expected 0", bus.o_mem_req_valid);
    else n_pass++;
    @(posedge clk);
    #1 bus.i_inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = 32'(4 * k);
      n_checks++;
      if ({bus.o_inst_valid, bus.o_inst_pc} !== {1'b1, exp})
        $display("[TB] FAIL stall_drain_%0d: got v=%b pc=%h expected v=1 pc=%h",
                 k, bus.o_inst_valid, bus.o_inst_pc, exp);
      else n_pass++;
      @(posedge clk);
    end
    #1;
    n_checks++;
    if (issue_log.size() < 5 || issue_log[4] !== 32'h10)
      $display("[TB] FAIL stall_resume: got %0d requests expected fifth at 00000010", issue_log.size());
    else n_pass++;
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    do_reset(1'b1, 1'b1);
    mem_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_mem_req_ready = 1'b0;
    bus.i_redirect      = 1'b1;
    bus.i_redirect_pc   = 32'h100;
    n_checks++;
    if (issue_log.size() != 2 || {issue_log[0], issue_log[1]} !== {32'h0, 32'h4})
      $display("[TB] FAIL redir_inflight: got %0d requests expected 2 (0,4)", issue_log.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.o_mem_req_valid !== 1'b0)
      $display("[TB] FAIL redir_no_issue: got %b expected 0", bus.o_mem_req_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.i_redirect      = 1'b0;
    bus.i_mem_req_ready = 1'b1;
    mem_hold            = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_inst_valid !== 1'b0)
        $display("[TB] FAIL redir_discard_%0d: got v=%b pc=%h expected v=0",
                 k, bus.o_inst_valid, bus.o_inst_pc);
      else n_pass++;
      @(posedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = 32'h100 + 32'(4 * k);
      n_checks++;
      if ({bus.o_inst_valid, bus.o_inst_pc, bus.o_inst} !== {1'b1, exp, exp})
        $display("[TB] FAIL redir_new_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, exp, exp);
      else n_pass++;
      @(posedge clk);
    end
  endtask

  task automatic test_redirect_collision();
    do_reset(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h102;
    @(negedge clk);
    n_checks++;
    if ({bus.o_inst_valid, bus.o_inst_pc, bus.o_mem_req_valid} !== {1'b1, 32'h0, 1'b0})
      $display("[TB] FAIL collide_pre: got v=%b pc=%h req=%b expected v=1 pc=00000000 req=0",
               bus.o_inst_valid, bus.o_inst_pc, bus.o_mem_req_valid);
    else n_pass++;
    @(posedge clk);
    #1 bus.i_redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_inst_valid, bus.o_mem_req_valid, bus.o_mem_req_addr} !== {1'b0, 1'b1, 32'h100})
      $display("[TB] FAIL collide_restart: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000100",
               bus.o_inst_valid, bus.o_mem_req_valid, bus.o_mem_req_addr);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.o_inst_valid !== 1'b0)
      $display("[TB] FAIL collide_old_stream: got v=%b pc=%h expected v=0",
               bus.o_inst_valid, bus.o_inst_pc);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.o_inst_valid, bus.o_inst_pc, bus.o_inst} !== {1'b1, 32'h100, 32'h100})
      $display("[TB] FAIL collide_first_new: got v=%b pc=%h inst=%h expected v=1 pc=00000100 inst=00000100",
               bus.o_inst_valid, bus.o_inst_pc, bus.o_inst);
    else n_pass++;
  endtask

  task automatic test_mem_backpressure();
    do_reset(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 bus.i_mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_mem_req_valid, bus.o_mem_req_addr} !== {1'b1, 32'h8})
        $display("[TB] FAIL bp_hold_%0d: got req=%b addr=%h expected req=1 addr=00000008",
                 k, bus.o_mem_req_valid, bus.o_mem_req_addr);
      else n_pass++;
      @(posedge clk);
    end
    #1 bus.i_mem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.o_mem_req_valid, bus.o_mem_req_addr} !== {1'b1, 32'h8})
      $display("[TB] FAIL bp_release: got req=%b addr=%h expected req=1 addr=00000008",
               bus.o_mem_req_valid, bus.o_mem_req_addr);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (issue_log.size() != 3 ||
        {issue_log[0], issue_log[1], issue_log[2]} !== {32'h0, 32'h4, 32'h8})
      $display("[TB] FAIL bp_single_issue: got %0d requests expected 3 (0,4,8)", issue_log.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.o_mem_req_valid, bus.o_mem_req_addr} !== {1'b1, 32'hC})
      $display("[TB] FAIL bp_next_addr: got req=%b addr=%h expected req=1 addr=0000000c",
               bus.o_mem_req_valid, bus.o_mem_req_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] exp;
    do_reset(1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.o_inst_valid, bus.o_inst_pc} !== {1'b1, 32'h0})
      $display("[TB] FAIL rstmid_before: got v=%b pc=%h expected v=1 pc=00000000",
               bus.o_inst_valid, bus.o_inst_pc);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.o_inst_valid, bus.o_mem_req_valid, bus.o_mem_req_addr, bus.o_inst_pc} !==
        {1'b0, 1'b0, 32'h0, 32'h0})
      $display("[TB] FAIL rstmid_cleared: got v=%b req=%b addr=%h pc=%h expected 0/0/00000000/00000000",
               bus.o_inst_valid, bus.o_mem_req_valid, bus.o_mem_req_addr, bus.o_inst_pc);
    else n_pass++;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.i_inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp = 32'(4 * k);
      n_checks++;
      if ({bus.o_inst_valid, bus.o_inst_pc, bus.o_inst} !== {1'b1, exp, exp})
        $display("[TB] FAIL rstmid_restart_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, exp, exp);
      else n_pass++;
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_decode_stall();
    test_redirect();
    test_redirect_collision();
    test_mem_backpressure();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of fetch slots (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, 32'h0, first fetch address after reset.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_redirect  input  1  flush and restart fetch (taken branch/jump).
REQ-006 SHALL have port i_redirect_pc  input  32  restart address.
REQ-007 SHALL have port o_mem_req_valid  output  1  instruction-memory request valid.
REQ-008 SHALL have port o_mem_req_addr  output  32  request word address.
REQ-009 SHALL have port i_mem_req_ready  input  1  memory accepts request.
REQ-010 SHALL have port i_mem_rsp_valid  input  1  in-order response valid, always accepted.
REQ-011 SHALL have port i_mem_rsp_data  input  32  response instruction word.
REQ-012 SHALL have port o_inst_valid  output  1  head instruction valid to decode.
REQ-013 SHALL have port o_inst  output  32  head instruction word.
REQ-014 SHALL have port o_inst_pc  output  32  address of o_inst.
REQ-015 SHALL have port i_inst_ready  input  1  decode consumes head.

Function
REQ-016 SHALL hold fetch_pc; o_mem_req_addr = fetch_pc, with bits[1:0] always 0.
REQ-017 SHALL issue (handshake) when o_mem_req_valid && i_mem_req_ready; fetch_pc += 4 (wraps modulo 2^32), and a slot is allocated at the FIFO tail, recording its pc, marked pending.
REQ-018 SHALL assert o_mem_req_valid iff !i_rst && !i_redirect && allocated < DEPTH && (live + drop) < DEPTH; depends on no other input.
REQ-019 SHALL keep o_mem_req_addr stable while o_mem_req_valid && !i_mem_req_ready, except on redirect.
REQ-020 SHALL track counters live (in-flight for current stream) and drop (in-flight stale), each log2(DEPTH)+1 bits.
REQ-021 SHALL, on response with drop>0, discard it and decrement drop; else with live>0, write data into oldest pending slot, mark filled, decrement live.
REQ-022 SHALL ignore a response when live==0 and drop==0 (protocol error, flagged by bench assertion).
REQ-023 SHALL register response data; no bypass: o_inst_valid rises earliest one cycle after the filling response.
REQ-024 SHALL drive o_inst_valid = head slot allocated and filled; o_inst/o_inst_pc from head slot.
REQ-025 SHALL pop head on o_inst_valid && i_inst_ready; freed slot is usable for issue the following cycle.
REQ-026 SHALL, on i_redirect: deallocate all slots, fetch_pc <= {i_redirect_pc[31:2],2'b00}, drop <= drop + live - (i_mem_rsp_valid ? 1 : 0), live <= 0; no issue that cycle.
REQ-027 SHALL give redirect priority over a same-cycle pop and same-cycle response (response discarded).
REQ-028 SHALL sustain one instruction per cycle with 1-cycle memory latency, always-ready memory and decode.
REQ-029 SHALL deliver instructions in strictly increasing-by-4 pc order between redirects.

Reset
REQ-030 SHALL, while i_rst high at a clock edge, set fetch_pc=RESET_PC, live=0, drop=0, all slots free; then o_mem_req_valid=0, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_mem_req_addr=RESET_PC.
REQ-031 SHALL apply i_rst with priority over redirect, issue, response and pop; responses to pre-reset requests SHALL not be delivered (bench drains memory model on reset).

Verification
REQ-032 SHALL cover: reset release, memory always ready, 1-cycle latency, data=addr -> o_inst_pc 0x0,0x4,0x8,... one per cycle from cycle 2, o_inst==o_inst_pc.
REQ-033 SHALL cover: i_inst_ready=0 -> exactly 4 requests (0x0..0xC), then o_mem_req_valid=0; ready=1 -> 0x0..0xC delivered in order, fetch resumes at 0x10.
REQ-034 SHALL cover: 2 requests in flight, redirect to 0x100 -> both responses discarded, drop returns to 0, next o_inst_pc=0x100.
REQ-035 SHALL cover: redirect to 0x102 in same cycle as response and pop -> response discarded, next request addr 0x100, no instruction from old stream.
REQ-036 SHALL cover: i_mem_req_ready low 3 cycles with addr 0x8 -> o_mem_req_valid and addr 0x8 held, single issue of 0x8 when ready rises.
REQ-037 SHALL cover: i_rst pulsed mid-stream with 3 slots filled -> o_inst_valid=0 next cycle, fetch restarts at RESET_PC.
